// File: rtl/accel_cmd_seq_pkg.sv
// Shared encodings for the accelerator command sequencer: FSM states, phases,
// bus op codes, bus IDs and completion status codes.
package accel_cmd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_RD   = 2'd0,
    PH_EXEC = 2'd1,
    PH_WR   = 2'd2
  } phase_t;

  localparam logic [1:0] OP_RD_FIRST = 2'b00;
  localparam logic [1:0] OP_RD_NEXT  = 2'b01;
  localparam logic [1:0] OP_EXEC     = 2'b11;
  localparam logic [1:0] OP_WR       = 2'b10;

  localparam logic [1:0] MEM_ID = 2'b00;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

endpackage

// File: rtl/accel_cmd_seq_ack_timer.sv
// ACK wait timer: counts while enabled, holds at LIMIT and flags expiry there.
// Shared by the command sequencers.
module ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] count_reg;

  assign expired = (count_reg == W'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/accel_cmd_seq.sv
// Command sequencer for one crypto accelerator: reads NUM_SRC operands, issues
// EXEC, writes the result back, with ACK timeout/retry, then posts a status word.
module accel_cmd_seq
  import accel_cmd_seq_pkg::*;
#(
  parameter int         ADDRW       = 24,
  parameter int         NUM_SRC     = 2,
  parameter logic [1:0] ACCEL_ID    = 2'b11,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         MAX_RETRY   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  input  logic [2+(NUM_SRC+1)*ADDRW-1:0]    req_data,
  output logic                              ready_req_out,
  input  logic                              compq_ready_in,
  output logic                              valid_compq_out,
  output logic [ADDRW+1:0]                  compq_data_out,
  output logic                              arb_req,
  input  logic                              arb_grant,
  input  logic [2:0]                        ack_in,
  output logic [ADDRW+7:0]                  data_out
);

  localparam int REQW = 2 + (NUM_SRC + 1) * ADDRW;
  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RETW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            state_reg, state_next;
  phase_t            phase_reg, phase_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic [RETW-1:0]   retry_reg, retry_next;
  logic [1:0]        status_reg, status_next;
  logic [REQW-1:0]   req_reg, req_next;

  logic [1:0]        mode;
  logic [ADDRW-1:0]  dst;
  logic [ADDRW-1:0]  src [NUM_SRC];
  logic [1:0]        exp_id;
  logic              ack_ok;
  logic              timer_expired;

  assign mode = req_reg[REQW-1 -: 2];
  assign dst  = req_reg[ADDRW-1:0];

  // src[0] sits directly above dst in the captured request word
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src[gi] = req_reg[(gi+1)*ADDRW +: ADDRW];
  end

  assign exp_id = (phase_reg == PH_EXEC) ? ACCEL_ID : MEM_ID;
  assign ack_ok = (state_reg == ST_WAIT) && ack_in[2] && (ack_in[1:0] == exp_id);

  // Timer only accumulates across consecutive WAIT cycles; any exit zeroes it
  ack_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_next != ST_WAIT),
    .enable  (state_reg == ST_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= PH_RD;
      idx_reg    <= '0;
      retry_reg  <= '0;
      status_reg <= STATUS_OK;
      req_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      idx_reg    <= idx_next;
      retry_reg  <= retry_next;
      status_reg <= status_next;
      req_reg    <= req_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    idx_next    = idx_reg;
    retry_next  = retry_reg;
    status_next = status_reg;
    req_next    = req_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          req_next    = req_data;
          state_next  = ST_ISSUE;
          phase_next  = PH_RD;
          idx_next    = '0;
          retry_next  = '0;
          status_next = STATUS_OK;
        end
      end
      ST_ISSUE: begin
        if (arb_grant) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A matching ACK wins over a timeout landing in the same cycle
        if (ack_ok) begin
          retry_next = '0;
          state_next = ST_ISSUE;
          case (phase_reg)
            PH_RD: begin
              if (idx_reg == IDXW'(NUM_SRC - 1)) phase_next = PH_EXEC;
              else                               idx_next   = idx_reg + IDXW'(1);
            end
            PH_EXEC: phase_next = PH_WR;
            default: begin
              state_next  = ST_DONE;
              status_next = STATUS_OK;
            end
          endcase
        end else if (timer_expired) begin
          if (retry_reg < RETW'(MAX_RETRY)) begin
            retry_next = retry_reg + RETW'(1);
            state_next = ST_ISSUE;
          end else begin
            state_next  = ST_DONE;
            status_next = STATUS_TIMEOUT;
          end
        end
      end
      default: begin
        if (compq_ready_in) state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_req_out   = (state_reg == ST_IDLE);
    arb_req         = (state_reg == ST_ISSUE);
    valid_compq_out = (state_reg == ST_DONE);
    compq_data_out  = '0;
    data_out        = '0;

    if (state_reg == ST_DONE) compq_data_out = {status_reg, dst};

    if (state_reg == ST_ISSUE || state_reg == ST_WAIT) begin
      case (phase_reg)
        PH_RD:   data_out = {src[idx_reg], 2'b00, ACCEL_ID, MEM_ID,
                             (idx_reg == '0) ? OP_RD_FIRST : OP_RD_NEXT};
        PH_EXEC: data_out = {{ADDRW{1'b0}}, mode, ACCEL_ID, 2'b00, OP_EXEC};
        default: data_out = {dst, 2'b00, MEM_ID, ACCEL_ID, OP_WR};
      endcase
    end
  end

endmodule

// File: tb/tb_accel_cmd_seq.sv
// Bench for accel_cmd_seq: directed request table, randomized requests against a
// step/attempt-level model of the command sequence, and reset corner cases.
module tb_accel_cmd_seq;

  localparam int         ADDRW       = 24;
  localparam int         NUM_SRC     = 2;
  localparam logic [1:0] ACCEL_ID    = 2'b11;
  localparam logic [1:0] MEM_ID      = 2'b00;
  localparam int         TIMEOUT_CYC = 4;
  localparam int         MAX_RETRY   = 2;
  localparam int         REQW        = 2 + (NUM_SRC + 1) * ADDRW;
  localparam int         DW          = ADDRW + 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [REQW-1:0]  req_data;
  logic             ready_req_out;
  logic             compq_ready_in;
  logic             valid_compq_out;
  logic [ADDRW+1:0] compq_data_out;
  logic             arb_req;
  logic             arb_grant;
  logic [2:0]       ack_in;
  logic [DW-1:0]    data_out;

  int tests = 0;
  int fails = 0;

  accel_cmd_seq #(
    .ADDRW(ADDRW), .NUM_SRC(NUM_SRC), .ACCEL_ID(ACCEL_ID),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .ready_req_out(ready_req_out), .compq_ready_in(compq_ready_in),
    .valid_compq_out(valid_compq_out), .compq_data_out(compq_data_out),
    .arb_req(arb_req), .arb_grant(arb_grant), .ack_in(ack_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gdelay;
    int ack_at;   // WAIT cycle index carrying the correct ACK; -1 = never
    bit wrong;    // fill earlier WAIT cycles with wrong-ID / invalid ACKs
  } plan_t;

  typedef struct {
    int               kind;
    logic [1:0]       mode;
    logic [ADDRW-1:0] s0, s1, dst;
    int               cq_delay;
    logic [1:0]       exp_status;
    int               exp_issues;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Bus word for step s: 0..NUM_SRC-1 reads, then EXEC, then WR
  function automatic logic [DW-1:0] exp_word(input int s, input logic [1:0] mode,
      input logic [ADDRW-1:0] s0, input logic [ADDRW-1:0] s1, input logic [ADDRW-1:0] dst);
    if (s == 0)            return {s0, 2'b00, ACCEL_ID, MEM_ID, 2'b00};
    else if (s < NUM_SRC)  return {s1, 2'b00, ACCEL_ID, MEM_ID, 2'b01};
    else if (s == NUM_SRC) return {{ADDRW{1'b0}}, mode, ACCEL_ID, 2'b00, 2'b11};
    else                   return {dst, 2'b00, MEM_ID, ACCEL_ID, 2'b10};
  endfunction

  function automatic plan_t make_plan(input int kind, input int step, input int attempt);
    plan_t p;
    p.gdelay = 0;
    p.ack_at = 0;
    p.wrong  = 1'b0;
    case (kind)
      1: if (step == 1) p.gdelay = 5;
      2: if (step == 0) begin p.ack_at = 2; p.wrong = 1'b1; end
      3: if (step == NUM_SRC) p.ack_at = -1;
      4: begin
        if (step == 0 && attempt == 0)     p.ack_at = -1;
        else if (step == 0)                p.ack_at = TIMEOUT_CYC;
        else if (step == 1 && attempt < 2) p.ack_at = -1;
      end
      5: begin
        p.gdelay = int'($urandom_range(0, 3));
        p.ack_at = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, TIMEOUT_CYC)) : -1;
        p.wrong  = bit'($urandom_range(0, 1));
      end
      default: ;
    endcase
    return p;
  endfunction

  // Drives one request end to end; the model walks steps/attempts and predicts words and status
  task automatic run_req(input int kind, input logic [1:0] mode, input logic [ADDRW-1:0] s0,
      input logic [ADDRW-1:0] s1, input logic [ADDRW-1:0] dst, input int cq_delay,
      output logic [1:0] got_status, output int n_issues);
    int            step, r, cyc;
    plan_t         p;
    logic [DW-1:0] w;
    logic [1:0]    exp_id;
    logic [1:0]    m_status;
    bit            ok, done;
    @(negedge clk);
    compq_ready_in = 1'b0;
    check("idle_ready", 64'(ready_req_out), 64'd1);
    check("idle_quiet", 64'({arb_req, valid_compq_out, data_out, compq_data_out}), 64'd0);
    req_valid = 1'b1;
    req_data  = {mode, s1, s0, dst};
    ack_in    = 3'($urandom);
    cyc = 0; step = 0; r = 0; n_issues = 0; m_status = 2'b00; done = 1'b0;
    @(negedge clk); cyc++;
    req_valid = 1'b0;
    req_data  = REQW'({$urandom(), $urandom(), $urandom()});
    while (!done) begin
      p      = make_plan(kind, step, r);
      w      = exp_word(step, mode, s0, s1, dst);
      exp_id = (step == NUM_SRC) ? ACCEL_ID : MEM_ID;
      for (int g = 0; g <= p.gdelay; g++) begin
        if (g > 0) begin @(negedge clk); cyc++; end
        check("issue_req", 64'(arb_req), 64'd1);
        check("issue_word", 64'(data_out), 64'(w));
        arb_grant = (g == p.gdelay);
        ack_in    = (kind == 1) ? {1'b1, exp_id} : 3'($urandom);
      end
      n_issues++;
      ok = 1'b0;
      for (int k = 0; k <= TIMEOUT_CYC; k++) begin
        @(negedge clk); cyc++;
        arb_grant = 1'b0;
        check("wait_req", 64'(arb_req), 64'd0);
        check("wait_word", 64'(data_out), 64'(w));
        if (k == p.ack_at) begin
          ack_in = {1'b1, exp_id};
          ok = 1'b1;
        end else if (p.wrong) begin
          ack_in = (k % 2 == 0) ? {1'b1, ~exp_id} : {1'b0, exp_id};
        end else begin
          ack_in = 3'b000;
        end
        if (ok) break;
      end
      @(negedge clk); cyc++;
      ack_in = 3'b000;
      if (ok) begin
        r = 0;
        step++;
        if (step == NUM_SRC + 2) done = 1'b1;
      end else begin
        r++;
        if (r > MAX_RETRY) begin
          m_status = 2'b01;
          done = 1'b1;
        end
      end
    end
    if (kind == 0) check("latency", 64'(cyc), 64'((NUM_SRC + 2) * 2 + 1));
    for (int d = 0; d <= cq_delay; d++) begin
      if (d > 0) @(negedge clk);
      check("done_valid", 64'(valid_compq_out), 64'd1);
      check("done_data", 64'(compq_data_out), 64'({m_status, dst}));
      check("done_quiet", 64'({arb_req, ready_req_out, data_out}), 64'd0);
      compq_ready_in = (d == cq_delay);
      ack_in = 3'($urandom);
    end
    got_status = compq_data_out[ADDRW+1:ADDRW];
    $display("[TB] req kind=%0d mode=%0d dst=%0h status=%0d issues=%0d", kind, mode, dst,
             got_status, n_issues);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    logic [1:0] st;
    int         iss;

    tbl[0] = '{0, 2'b10, 24'h111111, 24'h222222, 24'hABCDEF, 0, 2'b00, 4};
    tbl[1] = '{1, 2'b01, 24'h0000A0, 24'h0000B0, 24'h0000C0, 1, 2'b00, 4};
    tbl[2] = '{2, 2'b11, 24'h123456, 24'h654321, 24'h0F0F0F, 0, 2'b00, 4};
    tbl[3] = '{3, 2'b00, 24'hFFFFFF, 24'h800001, 24'h55AA55, 0, 2'b01, 5};
    tbl[4] = '{4, 2'b10, 24'h00BEEF, 24'h00CAFE, 24'h777777, 2, 2'b00, 7};
    tbl[5] = '{0, 2'b01, 24'h314159, 24'h271828, 24'h161803, 3, 2'b00, 4};

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0;
    compq_ready_in = 1'b0; arb_grant = 1'b0; ack_in = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_req_out), 64'd1);
    check("reset_quiet", 64'({arb_req, valid_compq_out, data_out, compq_data_out}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].kind, tbl[i].mode, tbl[i].s0, tbl[i].s1, tbl[i].dst, tbl[i].cq_delay, st, iss);
      check("tbl_status", 64'(st), 64'(tbl[i].exp_status));
      check("tbl_issues", 64'(iss), 64'(tbl[i].exp_issues));
    end

    for (int i = 0; i < 40; i++) begin
      run_req(5, 2'($urandom), ADDRW'($urandom), ADDRW'($urandom), ADDRW'($urandom),
              int'($urandom_range(0, 3)), st, iss);
    end

    // Reset while waiting on the first read ACK drops the request
    @(negedge clk);
    compq_ready_in = 1'b0;
    req_valid = 1'b1;
    req_data  = {2'b10, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C};
    @(negedge clk);
    req_valid = 1'b0;
    arb_grant = 1'b1;
    @(negedge clk);
    arb_grant = 1'b0;
    check("midrd_word", 64'(data_out), 64'({24'h0B0B0B, 2'b00, ACCEL_ID, MEM_ID, 2'b00}));
    rst_n = 1'b0;
    #1;
    check("midrd_rst_ready", 64'(ready_req_out), 64'd1);
    check("midrd_rst_quiet", 64'({arb_req, valid_compq_out, data_out, compq_data_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_quiet", 64'({arb_req, valid_compq_out, data_out, compq_data_out}), 64'd0);
    run_req(0, 2'b11, 24'h000001, 24'h000002, 24'h000003, 0, st, iss);
    check("post_rst_status", 64'(st), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
